// File: rtl/arb_mux_pkg.sv
// Shared constants and types for the arb_mux channel arbiter.
// Mode encodings are used by both the top and the bench.
package arb_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ARB_FIXED = MODE_FIXED,
        ARB_RR    = MODE_RR
    } arb_mode_e;

endpackage : arb_mux_pkg

// File: rtl/arb_mux_if.sv
// Handshake bundle between N producer channels, the arbiter and one consumer.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface arb_mux_if #(
    parameter int W    = 4,
    parameter int N    = 2,
    parameter int SELW = $clog2(N)
);
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SELW-1:0] sel;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_chan;
    logic            out_valid;
    logic            out_ready;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );
endinterface : arb_mux_if

// File: rtl/arb_mux_rr_pick.sv
// Combinational round-robin picker: first requester after i_ptr, wrapping
// from N-1 back to 0 and ending at i_ptr itself.
module rr_pick #(
    parameter int N    = 2,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [SELW-1:0] i_ptr,
    output logic [SELW-1:0] o_grant,
    output logic            o_any
);

    logic [SELW-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= N; i++) begin
            w_idx = SELW'((int'(i_ptr) + i) % N);
            if (!o_any && i_req[w_idx]) begin
                o_grant = w_idx;
                o_any   = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/arb_mux.sv
// N-channel to one registered output multiplexer with fixed-select or
// round-robin arbitration and a ready/valid output stage.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int W    = 4,
    parameter int N    = 2,
    parameter int SELW = $clog2(N)
) (
    input  logic      clk,
    input  logic      rst_n,
    arb_mux_if.slave  bus
);

    logic [W-1:0]    r_outData;
    logic [SELW-1:0] r_outChan;
    logic            r_outValid;
    logic [SELW-1:0] r_ptr;

    logic            w_load;
    logic [SELW-1:0] w_rrGrant;
    logic            w_rrAny;
    logic            w_fixAny;
    logic [SELW-1:0] w_grant;
    logic            w_grantValid;
    logic [W-1:0]    w_grantData;

    rr_pick #(.N(N), .SELW(SELW)) u_rrPick (
        .i_req   (bus.in_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_rrGrant),
        .o_any   (w_rrAny)
    );

    // Gating with rst_n keeps in_ready low while reset is held, even though
    // the empty output stage would otherwise be ready to load.
    assign w_load       = rst_n && (!r_outValid || bus.out_ready);
    assign w_fixAny     = (int'(bus.sel) < N) && bus.in_valid[bus.sel];
    assign w_grant      = (bus.mode == MODE_RR) ? w_rrGrant : bus.sel;
    assign w_grantValid = (bus.mode == MODE_RR) ? w_rrAny : w_fixAny;

    always_comb begin
        w_grantData = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == SELW'(i)) begin
                w_grantData = bus.in_data[i*W +: W];
            end
        end
    end

    assign bus.in_ready = (w_load && w_grantValid)
                        ? ({{(N-1){1'b0}}, 1'b1} << w_grant) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outChan  <= '0;
            r_ptr      <= SELW'(N - 1);
        end else if (w_load) begin
            r_outValid <= w_grantValid;
            if (w_grantValid) begin
                r_outData <= w_grantData;
                r_outChan <= w_grant;
                if (bus.mode == MODE_RR) begin
                    r_ptr <= w_grant;
                end
            end
        end
    end

    assign bus.out_data  = r_outData;
    assign bus.out_chan  = r_outChan;
    assign bus.out_valid = r_outValid;

endmodule : arb_mux

// File: tb/tb_arb_mux.sv
// Directed table-driven bench for arb_mux (N=2, W=4) with hand-written
// sequences for reset behaviour.
module tb_arb_mux;
    import arb_mux_pkg::*;

    localparam int W    = 4;
    localparam int N    = 2;
    localparam int SELW = 1;

    typedef struct {
        logic       mode;
        logic       sel;
        logic [1:0] inValid;
        logic [7:0] inData;
        logic       outReady;
        logic [1:0] expInReady;
        logic       expOutValid;
        logic [3:0] expOutData;
        logic       expOutChan;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   passes;
    vec_t vecs[18];

    arb_mux_if #(.W(W), .N(N), .SELW(SELW)) bus ();

    arb_mux #(.W(W), .N(N), .SELW(SELW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic applyStimulus(input logic mode, input logic sel,
                                 input logic [1:0] inValid,
                                 input logic [7:0] inData,
                                 input logic outReady);
        bus.mode      = mode;
        bus.sel       = sel;
        bus.in_valid  = inValid;
        bus.in_data   = inData;
        bus.out_ready = outReady;
    endtask

    initial begin
        checks = 0;
        passes = 0;

        // {mode, sel, in_valid, in_data{ch1,ch0}, out_ready, exp in_ready, exp out_valid, exp out_data, exp out_chan}
        vecs[0]  = '{MODE_FIXED, 1'b0, 2'b11, 8'b0101_0110, 1'b1, 2'b01, 1'b1, 4'b0110, 1'b0};
        vecs[1]  = '{MODE_FIXED, 1'b1, 2'b11, 8'b0101_0110, 1'b1, 2'b10, 1'b1, 4'b0101, 1'b1};
        vecs[2]  = '{MODE_RR,    1'b0, 2'b11, 8'b0101_0110, 1'b1, 2'b01, 1'b1, 4'b0110, 1'b0};
        vecs[3]  = '{MODE_RR,    1'b0, 2'b11, 8'b0101_0110, 1'b1, 2'b10, 1'b1, 4'b0101, 1'b1};
        vecs[4]  = '{MODE_RR,    1'b0, 2'b11, 8'b1110_0001, 1'b1, 2'b01, 1'b1, 4'b0001, 1'b0};
        vecs[5]  = '{MODE_RR,    1'b0, 2'b11, 8'b1110_0001, 1'b1, 2'b10, 1'b1, 4'b1110, 1'b1};
        vecs[6]  = '{MODE_RR,    1'b0, 2'b11, 8'b1111_1111, 1'b0, 2'b00, 1'b1, 4'b1110, 1'b1};
        vecs[7]  = '{MODE_RR,    1'b0, 2'b11, 8'b1111_1111, 1'b0, 2'b00, 1'b1, 4'b1110, 1'b1};
        vecs[8]  = '{MODE_RR,    1'b0, 2'b11, 8'b1111_1111, 1'b0, 2'b00, 1'b1, 4'b1110, 1'b1};
        vecs[9]  = '{MODE_RR,    1'b0, 2'b11, 8'b0101_0110, 1'b1, 2'b01, 1'b1, 4'b0110, 1'b0};
        vecs[10] = '{MODE_FIXED, 1'b1, 2'b01, 8'b0101_0110, 1'b1, 2'b00, 1'b0, 4'b0110, 1'b0};
        vecs[11] = '{MODE_FIXED, 1'b1, 2'b01, 8'b0101_0110, 1'b1, 2'b00, 1'b0, 4'b0110, 1'b0};
        vecs[12] = '{MODE_RR,    1'b0, 2'b11, 8'b0101_0110, 1'b1, 2'b10, 1'b1, 4'b0101, 1'b1};
        vecs[13] = '{MODE_FIXED, 1'b1, 2'b11, 8'b0101_0110, 1'b1, 2'b10, 1'b1, 4'b0101, 1'b1};
        vecs[14] = '{MODE_RR,    1'b0, 2'b11, 8'b1001_0011, 1'b1, 2'b01, 1'b1, 4'b0011, 1'b0};
        vecs[15] = '{MODE_RR,    1'b0, 2'b10, 8'b1100_1010, 1'b1, 2'b10, 1'b1, 4'b1100, 1'b1};
        vecs[16] = '{MODE_RR,    1'b0, 2'b10, 8'b1100_1010, 1'b1, 2'b10, 1'b1, 4'b1100, 1'b1};
        vecs[17] = '{MODE_RR,    1'b0, 2'b00, 8'b1100_1010, 1'b1, 2'b00, 1'b0, 4'b1100, 1'b1};

        // Reset state, with requests present so in_ready gating is exercised.
        rst_n = 1'b0;
        applyStimulus(MODE_RR, 1'b0, 2'b11, 8'b0101_0110, 1'b1);
        #1;
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset out_data",  32'(bus.out_data),  32'd0);
        checkOutput("reset out_chan",  32'(bus.out_chan),  32'd0);
        checkOutput("reset in_ready",  32'(bus.in_ready),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            if (i > 0) @(negedge clk);
            applyStimulus(vecs[i].mode, vecs[i].sel, vecs[i].inValid,
                          vecs[i].inData, vecs[i].outReady);
            #1;
            checkOutput($sformatf("v%0d in_ready", i), 32'(bus.in_ready),
                        32'(vecs[i].expInReady));
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d out_valid", i), 32'(bus.out_valid),
                        32'(vecs[i].expOutValid));
            checkOutput($sformatf("v%0d out_data", i), 32'(bus.out_data),
                        32'(vecs[i].expOutData));
            checkOutput($sformatf("v%0d out_chan", i), 32'(bus.out_chan),
                        32'(vecs[i].expOutChan));
        end

        // Load a word so a reset can land on a full output stage.
        @(negedge clk);
        applyStimulus(MODE_RR, 1'b0, 2'b01, 8'b0011_1001, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("pre-reset out_data",  32'(bus.out_data),  32'h9);

        #2;
        applyStimulus(MODE_RR, 1'b0, 2'b11, 8'b0011_1001, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("async reset out_data",  32'(bus.out_data),  32'd0);
        checkOutput("async reset out_chan",  32'(bus.out_chan),  32'd0);
        checkOutput("async reset in_ready",  32'(bus.in_ready),  32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(MODE_RR, 1'b0, 2'b11, 8'b0011_1001, 1'b1);
        #1;
        checkOutput("post-reset in_ready", 32'(bus.in_ready), 32'b01);
        @(posedge clk);
        #1;
        checkOutput("post-reset out_chan",  32'(bus.out_chan),  32'd0);
        checkOutput("post-reset out_data",  32'(bus.out_data),  32'h9);
        checkOutput("post-reset out_valid", 32'(bus.out_valid), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_arb_mux
